// File: rtl/am2302_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : am2302_frame_decoder
// Purpose  : Decodes one raw 40-bit AM2302 frame per transaction. It verifies
//            the checksum, range-checks humidity and temperature, and converts
//            both readings to 4-digit packed BCD using a double-dabble that
//            processes one bit per clock.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            i_frame_valid     raw frame present
//            i_frame_data[40]  [39:24] humidity, [23:8] temperature
//                              (bit 23 = sign), [7:0] checksum
//            o_frame_ready     decoder idle and able to accept a frame
//            o_out_valid       decoded result present (held until i_out_ready)
//            i_out_ready       consumer accepts the result
//            o_hum_bcd[16]     humidity, 4 BCD digits (0.1 %RH)
//            o_temp_bcd[16]    temperature magnitude, 4 BCD digits (0.1 degC)
//            o_temp_neg        temperature sign
//            o_crc_err         checksum mismatch
//            o_range_err       humidity > HUM_MAX or |temp| > TEMP_MAX
//            o_busy            any state other than IDLE
// Revision : 1.0 - initial release
// ============================================================================
module am2302_frame_decoder #(
  parameter int HUM_MAX  = 1000,
  parameter int TEMP_MAX = 800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_valid,
  input  logic [39:0] i_frame_data,
  output logic        o_frame_ready,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [15:0] o_hum_bcd,
  output logic [15:0] o_temp_bcd,
  output logic        o_temp_neg,
  output logic        o_crc_err,
  output logic        o_range_err,
  output logic        o_busy
);

  localparam logic [15:0] c_HUM_MAX  = 16'(HUM_MAX);
  localparam logic [15:0] c_TEMP_MAX = 16'(TEMP_MAX);
  localparam logic [15:0] c_BCD_SAT  = 16'd9999;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_CONV_H = 3'd2,
    S_CONV_T = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [39:0] r_frame;
  logic [31:0] r_shift;      // [31:16] BCD digits, [15:0] binary being shifted out
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_hum_bcd;
  logic [15:0] r_temp_bcd;
  logic        r_temp_neg;
  logic        r_crc_err;
  logic        r_range_err;

  logic [7:0]  w_sum;
  logic        w_crc_ok;
  logic [31:0] w_shift_nxt;
  logic        w_last_bit;
  logic [15:0] w_temp_mag;

  // Values above four decimal digits cannot be represented; clamp to 9999.
  function automatic logic [15:0] sat_bcd_range(input logic [15:0] v);
    return (v > c_BCD_SAT) ? c_BCD_SAT : v;
  endfunction

  // One double-dabble iteration: correct every BCD digit >= 5, then shift.
  function automatic logic [31:0] dd_step(input logic [31:0] v);
    logic [31:0] t;
    t = v;
    for (int d = 0; d < 4; d++) begin
      if (t[16+4*d +: 4] >= 4'd5) begin
        t[16+4*d +: 4] = t[16+4*d +: 4] + 4'd3;
      end
    end
    return {t[30:0], 1'b0};
  endfunction

  assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
  assign w_crc_ok    = (w_sum == r_frame[7:0]);
  assign w_shift_nxt = dd_step(r_shift);
  assign w_last_bit  = (r_bit_cnt == 4'd15);
  assign w_temp_mag  = {1'b0, r_frame[22:8]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_frame_valid) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_crc_ok ? S_CONV_H : S_DONE;
      S_CONV_H: if (w_last_bit) w_state_nxt = S_CONV_T;
      S_CONV_T: if (w_last_bit) w_state_nxt = S_DONE;
      S_DONE:   if (i_out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: frame capture, checks and the bit-serial conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame     <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_hum_bcd   <= '0;
      r_temp_bcd  <= '0;
      r_temp_neg  <= 1'b0;
      r_crc_err   <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_frame_valid) r_frame <= i_frame_data;
        end
        S_CHECK: begin
          r_hum_bcd  <= '0;
          r_temp_bcd <= '0;
          r_bit_cnt  <= '0;
          if (w_crc_ok) begin
            r_crc_err   <= 1'b0;
            r_temp_neg  <= r_frame[23];
            r_range_err <= (r_frame[39:24] > c_HUM_MAX) || (w_temp_mag > c_TEMP_MAX);
            r_shift     <= {16'h0000, sat_bcd_range(r_frame[39:24])};
          end else begin
            r_crc_err   <= 1'b1;
            r_temp_neg  <= 1'b0;
            r_range_err <= 1'b0;
          end
        end
        S_CONV_H: begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (w_last_bit) begin
            // Humidity done: publish it and preload the temperature magnitude.
            r_hum_bcd <= w_shift_nxt[31:16];
            r_shift   <= {16'h0000, sat_bcd_range(w_temp_mag)};
          end else begin
            r_shift <= w_shift_nxt;
          end
        end
        S_CONV_T: begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_shift   <= w_shift_nxt;
          if (w_last_bit) r_temp_bcd <= w_shift_nxt[31:16];
        end
        default: ;
      endcase
    end
  end

  assign o_frame_ready = (r_state == S_IDLE);
  assign o_out_valid   = (r_state == S_DONE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_hum_bcd     = r_hum_bcd;
  assign o_temp_bcd    = r_temp_bcd;
  assign o_temp_neg    = r_temp_neg;
  assign o_crc_err     = r_crc_err;
  assign o_range_err   = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_am2302_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2302_frame_decoder
// Purpose  : Self-checking bench for am2302_frame_decoder. Expected results
//            come from an independent behavioural model (decimal digit
//            arithmetic), are queued when a frame is driven and compared when
//            the decoder raises out_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am2302_frame_decoder;

  localparam int HUM_MAX  = 1000;
  localparam int TEMP_MAX = 800;

  logic        clk;
  logic        rst_n;
  logic        i_frame_valid;
  logic [39:0] i_frame_data;
  logic        o_frame_ready;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_hum_bcd;
  logic [15:0] o_temp_bcd;
  logic        o_temp_neg;
  logic        o_crc_err;
  logic        o_range_err;
  logic        o_busy;

  am2302_frame_decoder #(.HUM_MAX(HUM_MAX), .TEMP_MAX(TEMP_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_valid (i_frame_valid),
    .i_frame_data  (i_frame_data),
    .o_frame_ready (o_frame_ready),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_hum_bcd     (o_hum_bcd),
    .o_temp_bcd    (o_temp_bcd),
    .o_temp_neg    (o_temp_neg),
    .o_crc_err     (o_crc_err),
    .o_range_err   (o_range_err),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hum;
    logic [15:0] temp;
    logic        neg;
    logic        crc;
    logic        rng;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic exp_t model(input logic [39:0] f);
    exp_t       e;
    logic [7:0] s;
    int         hum;
    int         mag;
    s   = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    hum = int'(f[39:24]);
    mag = int'(f[22:8]);
    if (s != f[7:0]) begin
      e.hum = 16'h0; e.temp = 16'h0; e.neg = 1'b0; e.crc = 1'b1; e.rng = 1'b0; e.lat = 2;
    end else begin
      e.hum  = to_bcd(hum > 9999 ? 9999 : hum);
      e.temp = to_bcd(mag > 9999 ? 9999 : mag);
      e.neg  = f[23];
      e.crc  = 1'b0;
      e.rng  = (hum > HUM_MAX) || (mag > TEMP_MAX);
      e.lat  = 34;
    end
    return e;
  endfunction

  // Queue the expectation, wait for frame_ready, present the frame for one edge.
  task automatic send_frame(input logic [39:0] f);
    int k;
    sb.push_back(model(f));
    k = 0;
    @(negedge clk);
    while (!o_frame_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("frame_ready_before_send", o_frame_ready, 1);
    i_frame_valid = 1'b1;
    i_frame_data  = f;
    @(posedge clk);
    #1 i_frame_valid = 1'b0;
  endtask

  // Count negedges after the accept edge until out_valid is seen, then compare.
  task automatic wait_result(output exp_t e);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (o_out_valid) seen = 1'b1;
    end
    check("out_valid_timeout", seen, 1);
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
      e.hum = 0; e.temp = 0; e.neg = 0; e.crc = 0; e.rng = 0; e.lat = 0;
    end else begin
      e = sb.pop_front();
    end
    check("latency", k, e.lat);
    check("hum_bcd", o_hum_bcd, e.hum);
    check("temp_bcd", o_temp_bcd, e.temp);
    check("temp_neg", o_temp_neg, e.neg);
    check("crc_err", o_crc_err, e.crc);
    check("range_err", o_range_err, e.rng);
    check("busy_in_done", o_busy, 1);
    check("frame_ready_in_done", o_frame_ready, 0);
  endtask

  // With out_ready high the handshake completes on the next edge.
  task automatic after_handshake();
    @(negedge clk);
    check("out_valid_dropped", o_out_valid, 0);
    check("frame_ready_back", o_frame_ready, 1);
    check("busy_cleared", o_busy, 0);
  endtask

  task automatic run_frame(input logic [39:0] f);
    exp_t e;
    send_frame(f);
    wait_result(e);
    after_handshake();
  endtask

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    i_frame_valid = 1'b0;
    i_frame_data  = '0;
    i_out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_frame_ready", o_frame_ready, 1);
    check("rst_out_valid", o_out_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_hum", o_hum_bcd, 0);
    check("rst_temp", o_temp_bcd, 0);
    check("rst_flags", {o_temp_neg, o_crc_err, o_range_err}, 0);
    rst_n = 1'b1;

    // Nominal, negative temperature, bad checksum, range error, saturation, -0
    run_frame(40'h028C010F9E);
    run_frame(40'h028C806573);
    run_frame(40'h028C010F9F);
    run_frame(40'h0438010F4C);
    run_frame(40'h7FFF010F8E);
    run_frame(40'h028C80000E);

    // Backpressure: result held for 10 cycles, a competing frame is ignored
    i_out_ready = 1'b0;
    send_frame(40'h028C010F9E);
    wait_result(e);
    i_frame_valid = 1'b1;
    i_frame_data  = 40'h0438010F4C;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", o_out_valid, 1);
      check("bp_frame_ready", o_frame_ready, 0);
      check("bp_hum", o_hum_bcd, e.hum);
      check("bp_temp", o_temp_bcd, e.temp);
      check("bp_flags", {o_temp_neg, o_crc_err, o_range_err}, {e.neg, e.crc, e.rng});
    end
    i_frame_valid = 1'b0;
    i_out_ready   = 1'b1;
    after_handshake();
    run_frame(40'h028C806573);

    // Reset during the eighth humidity conversion cycle
    send_frame(40'h028C010F9E);
    repeat (8) @(posedge clk);
    #1;
    check("busy_before_reset", o_busy, 1);
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    check("midrst_frame_ready", o_frame_ready, 1);
    check("midrst_out_valid", o_out_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_bcd", {o_hum_bcd, o_temp_bcd}, 0);
    check("midrst_flags", {o_temp_neg, o_crc_err, o_range_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(40'h028C010F9E);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
